// File: rtl/fir_inverse_pkg.sv
// ============================================================================
// Module      : fir_inverse_pkg
// Description : Shared widths, tap coefficients and FSM encoding for the
//               fir_inverse recovery block.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package fir_inverse_pkg;

  localparam int DATA_W_DEFAULT = 8;
  localparam int NTAPS          = 5;
  localparam int K_W            = 3;

  // Coefficients of h0..h4 in the forward filter (x[n] term excluded)
  localparam logic [1:0] C [NTAPS] = '{2'd2, 2'd3, 2'd3, 2'd2, 2'd1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  function automatic logic [1:0] tap_coef(input logic [K_W-1:0] k);
    logic [1:0] c;
    c = 2'd0;
    if (k < K_W'(NTAPS)) c = C[k];
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fir_inverse_tap_mul.sv
// ============================================================================
// Module      : fir_inverse_tap_mul
// Description : Combinational C[k]*h product built from a shift and an add.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fir_inverse_tap_mul
  import fir_inverse_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic [K_W-1:0]    k,
  input  logic [DATA_W-1:0] h,
  output logic [DATA_W-1:0] prod
);

  logic [1:0]        w_coef;
  logic [DATA_W-1:0] w_dbl;

  // Coefficients are 0..3, so bit 1 selects 2h and bit 0 selects h
  always_comb begin
    w_coef = tap_coef(k);
    w_dbl  = {h[DATA_W-2:0], 1'b0};
    prod   = (w_coef[1] ? w_dbl : '0) + (w_coef[0] ? h : '0);
  end

endmodule

`default_nettype wire

// File: rtl/fir_inverse.sv
// ============================================================================
// Module      : fir_inverse
// Description : Recovers x[n] from the output of the 6-tap forward filter
//               1,2,3,3,2,1 by sequential subtraction of the history taps.
//               Define FIR_INVERSE_TAPS_OUT_EN to expose h0..h4 as x_0..x_4.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fir_inverse
  import fir_inverse_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
`ifdef FIR_INVERSE_TAPS_OUT_EN
  output logic [DATA_W-1:0]        x_0,
  output logic [DATA_W-1:0]        x_1,
  output logic [DATA_W-1:0]        x_2,
  output logic [DATA_W-1:0]        x_3,
  output logic [DATA_W-1:0]        x_4,
`endif
  output logic signed [DATA_W-1:0] out_data
);

  localparam logic [K_W-1:0] K_LAST = K_W'(NTAPS - 1);

  state_t            r_state;
  logic [K_W-1:0]    r_k;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_hist [NTAPS];
  logic              r_out_valid;

  logic [DATA_W-1:0] w_h_sel;
  logic [DATA_W-1:0] w_prod;
  logic              w_accept;
  logic              w_xfer;

  // Ready is combinational so the first edge after reset release can accept
  assign in_ready  = reset && !clear && (r_state == IDLE);
  assign w_accept  = in_valid && in_ready;
  assign w_xfer    = r_out_valid && out_ready && !clear;
  assign w_h_sel   = (r_k <= K_LAST) ? r_hist[r_k] : '0;
  assign out_valid = r_out_valid;
  assign out_data  = r_acc;

  fir_inverse_tap_mul #(
    .DATA_W (DATA_W)
  ) u_tap_mul (
    .k    (r_k),
    .h    (w_h_sel),
    .prod (w_prod)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_k         <= '0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      for (int i = 0; i < NTAPS; i++) r_hist[i] <= '0;
    end else if (clear) begin
      r_state     <= IDLE;
      r_k         <= '0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      for (int i = 0; i < NTAPS; i++) r_hist[i] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_acc   <= in_data;
            r_k     <= '0;
            r_state <= ACC;
          end
        end
        ACC: begin
          r_acc <= r_acc - w_prod;
          r_k   <= r_k + 1'b1;
          if (r_k == K_LAST) begin
            r_state     <= OUT;
            r_out_valid <= 1'b1;
          end
        end
        OUT: begin
          if (w_xfer) begin
            for (int i = NTAPS - 1; i > 0; i--) r_hist[i] <= r_hist[i-1];
            r_hist[0]   <= r_acc;
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIR_INVERSE_TAPS_OUT_EN
  assign x_0 = r_hist[0];
  assign x_1 = r_hist[1];
  assign x_2 = r_hist[2];
  assign x_3 = r_hist[3];
  assign x_4 = r_hist[4];
`endif

endmodule

`default_nettype wire

// File: tb/tb_fir_inverse.sv
// ============================================================================
// Module      : tb_fir_inverse
// Description : Randomised and directed stimulus for fir_inverse, compared
//               every cycle against a transaction-level model of the inverse.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_fir_inverse;

  localparam int W = 8;

  logic         clk       = 1'b0;
  logic         reset     = 1'b0;
  logic         clear     = 1'b0;
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] in_data   = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;

  fir_inverse #(
    .DATA_W (W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  // Model: one sample in flight, counted in edges since acceptance
  int m_hist [5];
  bit m_busy    = 1'b0;
  int m_cnt     = 0;
  int m_exp     = 0;
  bit m_has_lit = 1'b0;
  int m_lit     = 0;
  bit drv_has_lit = 1'b0;
  int drv_lit     = 0;

  int vectors     = 0;
  int miscompares = 0;

  function automatic int inv(input int y);
    int x;
    x = y - 2*m_hist[0] - 3*m_hist[1] - 3*m_hist[2] - 2*m_hist[3] - m_hist[4];
    return x & 255;
  endfunction

  task automatic model_zero();
    m_busy = 1'b0;
    m_cnt  = 0;
    for (int i = 0; i < 5; i++) m_hist[i] = 0;
  endtask

  task automatic model_update();
    if (!reset) return;
    if (clear) begin
      model_zero();
    end else if (m_busy) begin
      if (m_cnt == 5) begin
        if (out_ready) begin
          for (int i = 4; i > 0; i--) m_hist[i] = m_hist[i-1];
          m_hist[0] = m_exp;
          m_busy    = 1'b0;
        end
      end else begin
        m_cnt++;
      end
    end else if (in_valid) begin
      m_exp     = inv(int'(in_data));
      m_busy    = 1'b1;
      m_cnt     = 0;
      m_has_lit = drv_has_lit;
      m_lit     = drv_lit;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #2;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      #1;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_in_ready", int'(in_ready), 0);
    end else begin
      chk("in_ready", int'(in_ready), int'(!m_busy && !clear));
      chk("out_valid", int'(out_valid), int'(m_busy && m_cnt == 5));
      if (m_busy && m_cnt == 5) begin
        chk("out_data", int'(out_data), m_exp);
        if (m_has_lit) begin
          chk("out_data_literal", int'(out_data), m_lit);
          chk("model_literal", m_exp, m_lit);
        end
      end
    end
  end

  // Sends one sample from IDLE and waits for it to leave, holding
  // out_ready low for 'hold' cycles of OUT first.
  task automatic send(input int y, input bit has_lit, input int lit, input int hold);
    int waited;
    waited      = 0;
    out_ready   = (hold == 0);
    drv_has_lit = has_lit;
    drv_lit     = lit;
    in_valid    = 1'b1;
    in_data     = W'(y);
    tick();
    in_valid    = 1'b0;
    drv_has_lit = 1'b0;
    for (int g = 0; g < 64 && m_busy; g++) begin
      if (m_cnt == 5) begin
        if (waited >= hold) out_ready = 1'b1;
        waited++;
      end
      tick();
    end
    out_ready = 1'b1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    int imp_y [7];
    int stp_y [7];
    int imp_x [7];
    imp_y = '{1, 2, 3, 3, 2, 1, 0};
    imp_x = '{1, 0, 0, 0, 0, 0, 0};
    stp_y = '{1, 3, 6, 9, 11, 12, 12};
    model_zero();

    repeat (3) tick();
    reset = 1'b1;

    for (int i = 0; i < 7; i++) send(imp_y[i], 1'b1, imp_x[i], 0);

    pulse_clear();
    for (int i = 0; i < 7; i++) send(stp_y[i], 1'b1, 1, 0);

    pulse_clear();
    send(100, 1'b1, 100, 0);
    send(44, 1'b1, 100, 0);

    // History is 100,100,0,0,0 here
    send(44, 1'b1, 56, 10);
    send(0, 1'b1, 56, 0);

    // Clear lands on the third ACC cycle
    in_valid = 1'b1;
    in_data  = W'($urandom);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (8) tick();
    send(5, 1'b1, 5, 0);

    // Reset pulse while the sample waits in OUT
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = W'($urandom);
    tick();
    in_valid  = 1'b0;
    for (int g = 0; g < 10 && m_cnt != 5; g++) tick();
    #1;
    reset = 1'b0;
    model_zero();
    tick();
    reset     = 1'b1;
    out_ready = 1'b1;
    send(7, 1'b1, 7, 0);

    for (int n = 0; n < 1500; n++) begin
      in_valid  = 1'($urandom % 2);
      in_data   = W'($urandom);
      out_ready = ($urandom % 4) != 0;
      clear     = ($urandom % 50) == 0;
      tick();
    end
    in_valid  = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b1;
    repeat (10) tick();
    @(negedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
